// File: rtl/sa_2d_stream_if.sv
// Streaming interface of the systolic MAC array: job control, operand beats and result rows.
interface sa_2d_stream_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned HPE   = 4,
    parameter int unsigned VPE   = 4,
    parameter int unsigned ACCW  = 2 * WIDTH,
    parameter int unsigned KW    = 16,
    parameter int unsigned RW    = (VPE > 1) ? $clog2(VPE) : 1
);
    logic                   start;
    logic [KW-1:0]          k_len;
    logic                   signed_mode;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH*VPE-1:0]   aa;
    logic [WIDTH*HPE-1:0]   bb;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACCW*HPE-1:0]    y_row;
    logic [RW-1:0]          row_idx;
    logic                   busy;
    logic                   done;

    modport master (
        output start, k_len, signed_mode, in_valid, aa, bb, out_ready,
        input  in_ready, out_valid, y_row, row_idx, busy, done
    );

    modport slave (
        input  start, k_len, signed_mode, in_valid, aa, bb, out_ready,
        output in_ready, out_valid, y_row, row_idx, busy, done
    );
endinterface

// File: rtl/sa_2d_stream.sv
// Output-stationary VPE x HPE systolic MAC array with input skew, valid/ready streaming
// and row-serial result drain.
module sa_2d_stream #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned HPE   = 4,
    parameter int unsigned VPE   = 4,
    parameter int unsigned ACCW  = 2 * WIDTH,
    parameter int unsigned KW    = 16
) (
    input logic          clk,
    input logic          rst,
    sa_2d_stream_if.slave bus
);
    localparam int unsigned RW        = (VPE > 1) ? $clog2(VPE) : 1;
    localparam int unsigned PW        = 2 * WIDTH + 2;
    localparam int unsigned EW        = (ACCW > PW) ? ACCW : PW;
    localparam int unsigned FLUSH_LEN = VPE + HPE - 1;
    localparam int unsigned FW        = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDrain} state_e;

    state_e          state_q;
    logic [KW-1:0]   k_len_q;
    logic [KW-1:0]   beat_cnt_q;
    logic            signed_q;
    logic [FW-1:0]   flush_cnt_q;
    logic [RW-1:0]   row_q;
    logic            done_q;

    logic [WIDTH-1:0] a_dly  [VPE][VPE];
    logic [WIDTH-1:0] b_dly  [HPE][HPE];
    logic [WIDTH-1:0] a_pipe [VPE][HPE];
    logic [WIDTH-1:0] b_pipe [VPE][HPE];
    logic [ACCW-1:0]  acc    [VPE][HPE];

    logic [WIDTH-1:0] a_feed [VPE];
    logic [WIDTH-1:0] b_feed [HPE];
    logic [WIDTH-1:0] a_edge [VPE];
    logic [WIDTH-1:0] b_edge [HPE];
    logic [WIDTH-1:0] a_in   [VPE][HPE];
    logic [WIDTH-1:0] b_in   [VPE][HPE];
    logic [ACCW-1:0]  addend [VPE][HPE];

    logic fire;
    logic accumulate;
    logic clear;

    assign bus.in_ready  = (state_q == StFeed);
    assign bus.out_valid = (state_q == StDrain);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.row_idx   = row_q;

    assign fire       = bus.in_valid & bus.in_ready;
    assign accumulate = (state_q == StFeed) || (state_q == StFlush);
    assign clear      = (state_q == StIdle) && bus.start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            signed_q    <= 1'b0;
            flush_cnt_q <= '0;
            row_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        k_len_q     <= bus.k_len;
                        signed_q    <= bus.signed_mode;
                        beat_cnt_q  <= '0;
                        flush_cnt_q <= '0;
                        row_q       <= '0;
                        state_q     <= (bus.k_len == '0) ? StDrain : StFeed;
                    end
                end
                StFeed: begin
                    if (fire) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (beat_cnt_q == k_len_q - 1'b1) state_q <= StFlush;
                    end
                end
                StFlush: begin
                    // Long enough for the last beat to reach PE(VPE-1, HPE-1).
                    if (flush_cnt_q == FW'(FLUSH_LEN - 1)) state_q <= StDrain;
                    else flush_cnt_q <= flush_cnt_q + 1'b1;
                end
                StDrain: begin
                    if (bus.out_ready) begin
                        if (row_q == RW'(VPE - 1)) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        logic signed [PW-1:0] ea;
        logic signed [PW-1:0] eb;
        logic signed [PW-1:0] p;
        ea = '0;
        eb = '0;
        p  = '0;
        // Cycles without an accepted beat enter the array as zero bubbles.
        for (int r = 0; r < VPE; r++) begin
            a_feed[r] = fire ? bus.aa[r*WIDTH +: WIDTH] : '0;
            a_edge[r] = a_feed[r];
        end
        for (int r = 1; r < VPE; r++) a_edge[r] = a_dly[r][r-1];
        for (int c = 0; c < HPE; c++) begin
            b_feed[c] = fire ? bus.bb[c*WIDTH +: WIDTH] : '0;
            b_edge[c] = b_feed[c];
        end
        for (int c = 1; c < HPE; c++) b_edge[c] = b_dly[c][c-1];

        for (int r = 0; r < VPE; r++) begin
            a_in[r][0] = a_edge[r];
            for (int c = 1; c < HPE; c++) a_in[r][c] = a_pipe[r][c-1];
        end
        for (int c = 0; c < HPE; c++) begin
            b_in[0][c] = b_edge[c];
            for (int r = 1; r < VPE; r++) b_in[r][c] = b_pipe[r-1][c];
        end

        // One extra operand bit carries sign or zero so a single signed multiply covers both modes.
        for (int r = 0; r < VPE; r++) begin
            for (int c = 0; c < HPE; c++) begin
                ea = PW'($signed({signed_q & a_in[r][c][WIDTH-1], a_in[r][c]}));
                eb = PW'($signed({signed_q & b_in[r][c][WIDTH-1], b_in[r][c]}));
                p  = ea * eb;
                addend[r][c] = ACCW'(EW'(p));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int r = 0; r < VPE; r++) begin
                for (int i = 0; i < VPE; i++) a_dly[r][i] <= '0;
                for (int c = 0; c < HPE; c++) begin
                    a_pipe[r][c] <= '0;
                    b_pipe[r][c] <= '0;
                    acc[r][c]    <= '0;
                end
            end
            for (int c = 0; c < HPE; c++) begin
                for (int i = 0; i < HPE; i++) b_dly[c][i] <= '0;
            end
        end else begin
            for (int r = 0; r < VPE; r++) begin
                a_dly[r][0] <= a_feed[r];
                for (int i = 1; i < VPE; i++) a_dly[r][i] <= a_dly[r][i-1];
            end
            for (int c = 0; c < HPE; c++) begin
                b_dly[c][0] <= b_feed[c];
                for (int i = 1; i < HPE; i++) b_dly[c][i] <= b_dly[c][i-1];
            end
            for (int r = 0; r < VPE; r++) begin
                for (int c = 0; c < HPE; c++) begin
                    a_pipe[r][c] <= a_in[r][c];
                    b_pipe[r][c] <= b_in[r][c];
                    if (accumulate) acc[r][c] <= acc[r][c] + addend[r][c];
                end
            end
        end
    end

    always_comb begin
        bus.y_row = '0;
        for (int c = 0; c < HPE; c++) begin
            bus.y_row[c*ACCW +: ACCW] = (state_q == StDrain) ? acc[row_q][c] : '0;
        end
    end
endmodule
